// File: rtl/dmem_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_pkg
// Purpose  : Shared constants for the data-memory / MMIO responder:
//            MMIO register offsets, STATUS bit positions and the default
//            base address of the I/O page.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_mmio_pkg;

    // Word offsets within the I/O page (addr[3:2])
    localparam logic [1:0] OFF_CONS = 2'd0;
    localparam logic [1:0] OFF_STAT = 2'd1;
    localparam logic [1:0] OFF_CYC  = 2'd2;
    localparam logic [1:0] OFF_GPIO = 2'd3;

    // STATUS register bit positions
    localparam int EMPTY = 0;
    localparam int FULL  = 1;
    localparam int OVF   = 2;

    // Default base address of the I/O page
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF0000;

endpackage : dmem_mmio_pkg
`default_nettype wire

// File: rtl/dmem_mmio_responder_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Purpose  : Small synchronous byte FIFO for the console output path.
//            No bypass: a pushed byte becomes visible after the edge.
//            A push while full is accepted only if a pop happens in the
//            same cycle; otherwise it is ignored (caller flags overflow).
// Ports    : clk, reset (async, active-high)
//            push, din[7:0]  - enqueue request and data
//            pop             - dequeue request (ignored when empty)
//            dout[7:0]       - head byte, 0 when empty
//            empty, full     - occupancy flags
//            count           - number of stored bytes, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
    assign dout  = empty ? 8'h00 : r_mem[r_rd_ptr];

    // A pop frees the slot the simultaneous push needs, so a full FIFO
    // still accepts a push in a pop cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage holds no reset: contents are only observable through count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are power-of-two wide, so plain increment wraps mod DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_responder
// Purpose  : Data-memory responder for a single-cycle MIPS core. Provides a
//            word RAM at address 0 and a four-register I/O page at MMIO_BASE
//            (console FIFO, STATUS, free-running CYCLE counter, GPIO).
//            Reads are combinational; all state changes on the rising edge.
// Ports    : clk, reset (async, active-high)
//            memwrite, addr[31:0], writedata[31:0] - core store/load port
//            readdata[31:0]                         - combinational load data
//            cons_valid, cons_data[7:0], cons_ready - console byte stream
//            gpio_out[31:0]                         - GPIO register
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready,
    output logic [31:0] gpio_out
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    // ------------------------------------------------------------------
    // Address decode (addr[1:0] ignored: every access is word aligned)
    // ------------------------------------------------------------------
    logic          w_ram_hit;
    logic          w_mmio_hit;
    logic [1:0]    w_off;
    logic [AW-1:0] w_idx;

    assign w_ram_hit  = (addr < RAM_BYTES);
    assign w_mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
    assign w_off      = addr[3:2];
    assign w_idx      = addr[AW+1:2];

    logic w_wr_cons;
    logic w_wr_stat;
    logic w_wr_cyc;
    logic w_wr_gpio;

    assign w_wr_cons = memwrite && w_mmio_hit && (w_off == OFF_CONS);
    assign w_wr_stat = memwrite && w_mmio_hit && (w_off == OFF_STAT);
    assign w_wr_cyc  = memwrite && w_mmio_hit && (w_off == OFF_CYC);
    assign w_wr_gpio = memwrite && w_mmio_hit && (w_off == OFF_GPIO);

    // ------------------------------------------------------------------
    // RAM: write at the edge, read combinationally (pre-edge value)
    // ------------------------------------------------------------------
    logic [31:0] r_mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (memwrite && w_ram_hit) begin
            r_mem[w_idx] <= writedata;
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic             w_pop;
    logic [7:0]       w_fifo_dout;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_count;

    assign w_pop = cons_ready && !w_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_wr_cons),
        .din   (writedata[7:0]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    assign cons_valid = !w_empty;
    assign cons_data  = w_fifo_dout;

    // ------------------------------------------------------------------
    // Overflow, CYCLE and GPIO registers
    // ------------------------------------------------------------------
    logic        r_ovf;
    logic [31:0] r_cycle;
    logic [31:0] r_gpio;
    logic        w_ovf_set;

    // Dropped byte: push into a full FIFO with no pop freeing a slot.
    assign w_ovf_set = w_wr_cons && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf   <= 1'b0;
            r_cycle <= '0;
            r_gpio  <= '0;
        end else begin
            // Set beats clear when both happen in one cycle.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat) begin
                r_ovf <= 1'b0;
            end

            if (w_wr_cyc) begin
                r_cycle <= writedata;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end

            if (w_wr_gpio) begin
                r_gpio <= writedata;
            end
        end
    end

    assign gpio_out = r_gpio;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_status;

    always_comb begin
        w_status        = '0;
        w_status[31:8]  = 24'(w_count);
        w_status[OVF]   = r_ovf;
        w_status[FULL]  = w_full;
        w_status[EMPTY] = w_empty;
    end

    always_comb begin
        readdata = '0;
        if (w_ram_hit) begin
            readdata = r_mem[w_idx];
        end else if (w_mmio_hit) begin
            case (w_off)
                OFF_CONS: readdata = {24'h0, w_fifo_dout};
                OFF_STAT: readdata = w_status;
                OFF_CYC:  readdata = r_cycle;
                default:  readdata = r_gpio;
            endcase
        end
    end

endmodule : dmem_mmio_responder
`default_nettype wire
